// File: rtl/pc_fetch_stage_if.sv
// Bundle of the fetch-stage control, target and IF/ID signals.
// Only the scalar clock and reset stay outside it, as plain module ports.
//
// Handshake: IF_ID_Valid qualifies the IF/ID register. When it is 1, IF_ID_Instr
// and IF_ID_PCPlus4 hold a real fetched instruction. When it is 0, they hold a
// bubble, which is all zeros. Stall is the only backpressure, and it holds both
// the PC and IF/ID. Redirect is combinational and reports that a redirect is
// being applied on the coming edge.
`timescale 1ns/1ps
interface pc_fetch_stage_if;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpPC;
  logic        JumpReg;
  logic [31:0] JumpRegTarget;
  logic [31:0] InstrIn;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [3:0]  PCUpper;
  logic        Redirect;
  logic        AlignErr;
  // Debug view of the fetch FSM: 0 = BOOT, 1 = RUN, 2 = FAULT.
  logic [1:0]  DbgState;

  // Fetch stage side.
  modport slave (
    input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpPC,
           JumpReg, JumpRegTarget, InstrIn,
    output PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, PCUpper,
           Redirect, AlignErr, DbgState
  );

  // Hazard unit, decode and instruction memory side.
  modport master (
    output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpPC,
           JumpReg, JumpRegTarget, InstrIn,
    input  PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, PCUpper,
           Redirect, AlignErr, DbgState
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// MIPS fetch stage. It holds the program-counter register, selects the next PC
// and owns the IF/ID pipeline register.
//
// Optional feature macro: PC_ALIGN_CHECK_EN.
//   Defined:   a redirect to a target with [1:0] != 00 freezes the stage in FAULT
//              and raises AlignErr. Only reset leaves FAULT.
//   Undefined: the low two bits of the selected target are cleared before the
//              target is loaded, FAULT is never reached, and AlignErr is 0.
`timescale 1ns/1ps
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  pc_fetch_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] sel_target;
  logic [31:0] load_target;
  logic [31:0] pc_plus_inc;
  logic        target_misaligned;

  // Control inputs only act in RUN. BOOT and FAULT ignore them entirely.
  assign redirect = (state_q == ST_RUN) &&
                    (bus.JumpReg || bus.Jump || bus.BranchTaken);

  // Select the target by fixed priority: JR first, then J/JAL, then a taken branch.
  always_comb begin
    sel_target = bus.BranchTarget;
    if (bus.JumpReg) begin
      sel_target = bus.JumpRegTarget;
    end else if (bus.Jump) begin
      sel_target = bus.JumpPC;
    end
  end

  // Clearing the low bits is harmless when the alignment check is enabled,
  // because a misaligned target is never loaded in that build.
  assign load_target = sel_target & ~32'h0000_0003;

  // Sequential increment wraps modulo 2^32 and raises no flag.
  assign pc_plus_inc = pc_q + PC_INC;

`ifdef PC_ALIGN_CHECK_EN
  assign target_misaligned = (sel_target[1:0] != 2'b00);
`else
  assign target_misaligned = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. BOOT lasts exactly one edge and FAULT is sticky.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (redirect && target_misaligned) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // FSM outputs: next values of the PC and IF/ID, applied in priority order.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          // A redirect overrides both Stall and Flush.
          instr_d = 32'h0000_0000;
          pcp4_d  = 32'h0000_0000;
          valid_d = 1'b0;
          if (!target_misaligned) begin
            pc_d = load_target;
          end
        end else if (bus.Stall) begin
          // Hold the PC and IF/ID unchanged.
          pc_d = pc_q;
        end else if (bus.Flush) begin
          pc_d    = pc_plus_inc;
          instr_d = 32'h0000_0000;
          pcp4_d  = 32'h0000_0000;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_plus_inc;
          instr_d = bus.InstrIn;
          pcp4_d  = pc_plus_inc;
          valid_d = 1'b1;
        end
      end
      default: begin
        // BOOT and FAULT keep the PC where it is and feed bubbles to decode.
        instr_d = 32'h0000_0000;
        pcp4_d  = 32'h0000_0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // PC and IF/ID registers. Reset clears them at once, without waiting for a clock.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pcp4_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;

  // AlignErr latches on the misaligned redirect and only reset clears it.
  always_comb begin
    align_err_d = align_err_q | (redirect & target_misaligned);
  end

  // Sticky fault flag register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign bus.AlignErr = align_err_q;
`else
  assign bus.AlignErr = 1'b0;
`endif

  assign bus.PC            = pc_q;
  assign bus.IF_ID_Instr   = instr_q;
  assign bus.IF_ID_PCPlus4 = pcp4_q;
  assign bus.IF_ID_Valid   = valid_q;
  assign bus.PCUpper       = pcp4_q[31:28];
  assign bus.Redirect      = redirect;
  assign bus.DbgState      = state_q;

endmodule
